// File: rtl/board_io_debouncer.sv
// Board button/switch conditioner: synchroniser, polarity fix, stable-count debounce, edges, sticky pending, irq.
// Latency SYNC_STAGES+STABLE_CYCLES edges raw->level_o; irq_o one cycle after pend_o; no backpressure (inputs always sampled).
module board_io_debouncer #(
  parameter int              NUM_CH        = 5,
  parameter int              SYNC_STAGES   = 2,
  parameter int              STABLE_CYCLES = 65536,
  parameter logic [NUM_CH-1:0] INV_MASK    = '0,
  parameter logic [NUM_CH-1:0] RISE_EN     = '1,
  parameter logic [NUM_CH-1:0] FALL_EN     = '0
) (
  input  logic              ref_clk,
  input  logic              pad_reset_n,
  input  logic [NUM_CH-1:0] raw_i,
  input  logic [NUM_CH-1:0] irq_en_i,
  input  logic [NUM_CH-1:0] clr_i,
  output logic [NUM_CH-1:0] level_o,
  output logic [NUM_CH-1:0] rise_o,
  output logic [NUM_CH-1:0] fall_o,
  output logic [NUM_CH-1:0] pend_o,
  output logic              irq_o
);

  localparam int CW = $clog2(STABLE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

  logic [SYNC_STAGES-1:0][NUM_CH-1:0] sync_q, sync_d;
  logic [NUM_CH-1:0][CW-1:0]          cnt_q, cnt_d;
  logic [NUM_CH-1:0]                  level_q, level_d;
  logic [NUM_CH-1:0]                  rise_q, rise_d;
  logic [NUM_CH-1:0]                  fall_q, fall_d;
  logic [NUM_CH-1:0]                  pend_q, pend_d;
  logic                               irq_q, irq_d;
  logic [NUM_CH-1:0]                  sq;
  logic [NUM_CH-1:0]                  ev;

  assign sq = sync_q[SYNC_STAGES-1] ^ INV_MASK;

  always_comb begin
    sync_d[0] = raw_i;
    for (int k = 1; k < SYNC_STAGES; k++) begin
      sync_d[k] = sync_q[k-1];
    end
  end

  // A new value is accepted only after persisting for STABLE_CYCLES consecutive cycles.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    rise_d  = '0;
    fall_d  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (sq[i] != level_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          level_d[i] = sq[i];
          rise_d[i]  = sq[i];
          fall_d[i]  = ~sq[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  // Event set takes priority over a simultaneous clear.
  assign ev = (rise_d & RISE_EN) | (fall_d & FALL_EN);

  always_comb begin
    pend_d = ev | (pend_q & ~clr_i);
    irq_d  = |(pend_q & irq_en_i);
  end

  always_ff @(posedge ref_clk) begin
    if (!pad_reset_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= INV_MASK;
      end
      cnt_q   <= '0;
      level_q <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      pend_q  <= '0;
      irq_q   <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      pend_q  <= pend_d;
      irq_q   <= irq_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;
  assign pend_o  = pend_q;
  assign irq_o   = irq_q;

endmodule

// File: tb/tb_board_io_debouncer.sv
// Directed bench for board_io_debouncer (5 ch, 2 sync stages, 4 stable cycles) plus a lock-step model phase.
module tb_board_io_debouncer;

  localparam int NCH = 5;
  localparam int STB = 4;
  localparam logic [NCH-1:0] INV = 5'b00001;
  localparam logic [NCH-1:0] REN = 5'b11111;
  localparam logic [NCH-1:0] FEN = 5'b00011;

  logic           ref_clk;
  logic           pad_reset_n;
  logic [NCH-1:0] raw_i, irq_en_i, clr_i;
  logic [NCH-1:0] level_o, rise_o, fall_o, pend_o;
  logic           irq_o;

  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  logic [NCH-1:0] m_s0, m_s1, m_lvl, m_rise, m_fall, m_pend;
  logic           m_irq;
  int             m_cnt [NCH];
  int             hold  [NCH];

  board_io_debouncer #(
    .NUM_CH(NCH), .SYNC_STAGES(2), .STABLE_CYCLES(STB),
    .INV_MASK(INV), .RISE_EN(REN), .FALL_EN(FEN)
  ) dut (
    .ref_clk(ref_clk), .pad_reset_n(pad_reset_n), .raw_i(raw_i),
    .irq_en_i(irq_en_i), .clr_i(clr_i), .level_o(level_o), .rise_o(rise_o),
    .fall_o(fall_o), .pend_o(pend_o), .irq_o(irq_o)
  );

  initial begin
    ref_clk = 1'b0;
    forever #5 ref_clk = ~ref_clk;
  end

  task automatic tick();
    @(posedge ref_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_s0 = INV; m_s1 = INV;
    m_lvl = '0; m_rise = '0; m_fall = '0; m_pend = '0; m_irq = 1'b0;
    for (int i = 0; i < NCH; i++) m_cnt[i] = 0;
  endtask

  // One rising edge of the spec behaviour, from pre-edge state and current inputs.
  task automatic model_step();
    logic [NCH-1:0] sqm, r, f, ev;
    sqm = m_s1 ^ INV;
    r = '0; f = '0;
    for (int i = 0; i < NCH; i++) begin
      if (sqm[i] == m_lvl[i]) m_cnt[i] = 0;
      else if (m_cnt[i] < STB - 1) m_cnt[i] = m_cnt[i] + 1;
      else begin
        m_cnt[i] = 0;
        m_lvl[i] = sqm[i];
        r[i] = sqm[i];
        f[i] = ~sqm[i];
      end
    end
    ev     = (r & REN) | (f & FEN);
    m_irq  = |(m_pend & irq_en_i);
    m_pend = ev | (m_pend & ~clr_i);
    m_rise = r;
    m_fall = f;
    m_s1   = m_s0;
    m_s0   = raw_i;
  endtask

  initial begin
    pad_reset_n = 1'b0;
    raw_i = 5'b00001;
    irq_en_i = '0;
    clr_i = '0;

    // reset state, with ch0 (active-low) idle high
    tick(); tick();
    check("rst_level", level_o, 0);
    check("rst_rise", rise_o, 0);
    check("rst_fall", fall_o, 0);
    check("rst_pend", pend_o, 0);
    check("rst_irq", irq_o, 0);
    pad_reset_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      tick();
      check("idle_level", level_o, 0);
      check("idle_edges", rise_o | fall_o, 0);
    end

    // ch1 press: level/rise at edge 6
    raw_i = 5'b00011;
    for (int c = 0; c < 5; c++) tick();
    check("t1_level_e5", level_o, 0);
    tick();
    check("t1_level_e6", level_o, 5'b00010);
    check("t1_rise_e6", rise_o, 5'b00010);
    check("t1_pend_e6", pend_o, 5'b00010);
    tick();
    check("t1_rise_e7", rise_o, 0);
    check("t1_level_e7", level_o, 5'b00010);
    check("t1_irq_disabled", irq_o, 0);

    // enable irq, then clear pending
    irq_en_i = 5'b00010;
    tick();
    check("t4_irq_on", irq_o, 1);
    clr_i = 5'b00010;
    tick();
    clr_i = '0;
    check("t4_pend_clr", pend_o, 0);
    check("t4_irq_lag", irq_o, 1);
    tick();
    check("t4_irq_off", irq_o, 0);

    // ch2 glitch of 3 cycles is rejected
    raw_i = 5'b00111;
    tick(); tick(); tick();
    raw_i = 5'b00011;
    for (int c = 0; c < 8; c++) begin
      tick();
      check("t2_level", level_o, 5'b00010);
      check("t2_pend", pend_o, 0);
      check("t2_rise", rise_o, 0);
    end

    // ch1 release with clear on the same edge as the fall
    raw_i = 5'b00001;
    for (int c = 0; c < 5; c++) tick();
    check("t4_level_e5", level_o, 5'b00010);
    clr_i = 5'b00010;
    tick();
    clr_i = '0;
    check("t4_fall_e6", fall_o, 5'b00010);
    check("t4_rise_e6", rise_o, 0);
    check("t4_level_e6", level_o, 0);
    check("t4_pend_setwins", pend_o, 5'b00010);
    tick();
    check("t4_irq_after_fall", irq_o, 1);
    check("t4_fall_e7", fall_o, 0);
    check("t4_pend_sticky", pend_o, 5'b00010);
    clr_i = 5'b00010;
    tick();
    clr_i = '0;
    check("t4_pend_clr2", pend_o, 0);

    // ch0 active-low press
    raw_i = 5'b00000;
    for (int c = 0; c < 5; c++) tick();
    check("t3_level_e5", level_o, 0);
    tick();
    check("t3_level_e6", level_o, 5'b00001);
    check("t3_rise_e6", rise_o, 5'b00001);
    check("t3_pend_e6", pend_o, 5'b00001);
    tick();
    check("t3_irq_masked", irq_o, 0);

    // reset mid-debounce on ch3 discards progress
    raw_i = 5'b01000;
    for (int c = 0; c < 4; c++) tick();
    pad_reset_n = 1'b0;
    tick();
    check("t5_rst_level", level_o, 0);
    check("t5_rst_pend", pend_o, 0);
    check("t5_rst_irq", irq_o, 0);
    pad_reset_n = 1'b1;
    for (int c = 0; c < 5; c++) tick();
    check("t5_level_e5", level_o, 0);
    check("t5_rise_e5", rise_o, 0);
    tick();
    check("t5_level_e6", level_o, 5'b01001);
    check("t5_rise_e6", rise_o, 5'b01001);
    check("t5_pend_e6", pend_o, 5'b01001);

    // bouncy stimuli in lock-step with the model
    pad_reset_n = 1'b0;
    tick();
    model_reset();
    pad_reset_n = 1'b1;
    for (int i = 0; i < NCH; i++) hold[i] = $urandom_range(1, 7);
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NCH; i++) begin
        hold[i] = hold[i] - 1;
        if (hold[i] == 0) begin
          raw_i[i] = ~raw_i[i];
          hold[i] = $urandom_range(1, 7);
        end
        clr_i[i] = ($urandom_range(0, 7) == 0);
      end
      if ((c % 16) == 0) irq_en_i = NCH'($urandom_range(0, 31));
      model_step();
      tick();
      check("r_level", level_o, m_lvl);
      check("r_rise", rise_o, m_rise);
      check("r_fall", fall_o, m_fall);
      check("r_pend", pend_o, m_pend);
      check("r_irq", irq_o, m_irq);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
